// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage
//  Purpose  : ID/EX pipeline register of the 5-stage MIPS pipeline.
//             - Captures the ten decoder control outputs and the ID-stage
//               operands into the EX stage.
//             - Detects load-use hazards. A hazard stalls PC and IF/ID and
//               inserts one bubble.
//             - Inserts a bubble on flush.
//             - Keeps a saturating count of inserted bubbles.
//  Ports    : clk, rst_n (async, active-low)
//             decoder controls in      : RegDest .. Jump
//             ID operands in           : id_valid, id_pc4, id_rd1, id_rd2,
//                                        id_imm, id_rs, id_rt, id_rd
//             flush in                 : kill the ID instruction
//             ex_* out                 : registered controls, data, addresses
//             stall / pc_write / ifid_write out : hazard handshake upstream
//             bubble_cnt out           : saturating bubble counter
//  Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // decoder controls for the instruction in ID
    input  logic              RegDest,
    input  logic              Branch,
    input  logic              MemRead,
    input  logic              MemToReg,
    input  logic              ALUOp1,
    input  logic              ALUOp2,
    input  logic              MemWrite,
    input  logic              ALUSrc,
    input  logic              RegWrite,
    input  logic              Jump,
    // ID operands
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [15:0]       id_imm,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              flush,
    // EX-stage registered outputs
    output logic              ex_RegDest,
    output logic              ex_Branch,
    output logic              ex_MemRead,
    output logic              ex_MemToReg,
    output logic              ex_MemWrite,
    output logic              ex_ALUSrc,
    output logic              ex_RegWrite,
    output logic              ex_Jump,
    output logic [1:0]        ex_ALUOp,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    // hazard handshake and debug
    output logic              stall,
    output logic              pc_write,
    output logic              ifid_write,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Control bundle order: RegDest, Branch, MemRead, MemToReg,
    //                       MemWrite, ALUSrc, RegWrite, Jump
    localparam int c_CTRL_W = 8;

    logic [c_CTRL_W-1:0] r_ctrl;
    logic [1:0]          r_aluop;
    logic                r_valid;
    logic [DATA_W-1:0]   r_pc4;
    logic [DATA_W-1:0]   r_rd1;
    logic [DATA_W-1:0]   r_rd2;
    logic [DATA_W-1:0]   r_imm;
    logic [REG_W-1:0]    r_rs;
    logic [REG_W-1:0]    r_rt;
    logic [REG_W-1:0]    r_rd;
    logic [CNT_W-1:0]    r_bubble_cnt;

    logic                w_stall;
    logic                w_bubble;
    logic                w_cnt_sat;
    logic [c_CTRL_W-1:0] w_id_ctrl;

    // Load-use hazard: the load in EX writes a register the ID instruction
    // reads. Register 0 is deliberately not exempted.
    assign w_stall = r_valid & r_ctrl[5] & id_valid &
                     ((r_rt == id_rs) | (r_rt == id_rt));

    // Flush and stall collapse into a single bubble.
    assign w_bubble  = flush | w_stall;
    assign w_cnt_sat = &r_bubble_cnt;

    assign w_id_ctrl = {RegDest, Branch, MemRead, MemToReg,
                        MemWrite, ALUSrc, RegWrite, Jump};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl       <= '0;
            r_aluop      <= '0;
            r_valid      <= 1'b0;
            r_pc4        <= '0;
            r_rd1        <= '0;
            r_rd2        <= '0;
            r_imm        <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_bubble_cnt <= '0;
        end else begin
            // Data and address fields are captured even for a bubble; with
            // controls and valid cleared they are simply ignored downstream.
            r_pc4 <= id_pc4;
            r_rd1 <= id_rd1;
            r_rd2 <= id_rd2;
            r_imm <= {{(DATA_W-16){id_imm[15]}}, id_imm};
            r_rs  <= id_rs;
            r_rt  <= id_rt;
            r_rd  <= id_rd;

            if (w_bubble) begin
                r_ctrl  <= '0;
                r_aluop <= '0;
                r_valid <= 1'b0;
                if (!w_cnt_sat) begin
                    r_bubble_cnt <= r_bubble_cnt + 1'b1;
                end
            end else begin
                // An empty ID slot travels as a bubble but is not counted.
                r_ctrl  <= id_valid ? w_id_ctrl : '0;
                r_aluop <= id_valid ? {ALUOp1, ALUOp2} : 2'b00;
                r_valid <= id_valid;
            end
        end
    end

    assign ex_RegDest  = r_ctrl[7];
    assign ex_Branch   = r_ctrl[6];
    assign ex_MemRead  = r_ctrl[5];
    assign ex_MemToReg = r_ctrl[4];
    assign ex_MemWrite = r_ctrl[3];
    assign ex_ALUSrc   = r_ctrl[2];
    assign ex_RegWrite = r_ctrl[1];
    assign ex_Jump     = r_ctrl[0];
    assign ex_ALUOp    = r_aluop;
    assign ex_valid    = r_valid;
    assign ex_pc4      = r_pc4;
    assign ex_rd1      = r_rd1;
    assign ex_rd2      = r_rd2;
    assign ex_imm      = r_imm;
    assign ex_rs       = r_rs;
    assign ex_rt       = r_rt;
    assign ex_rd       = r_rd;

    assign stall      = w_stall;
    assign pc_write   = ~w_stall;
    assign ifid_write = ~w_stall;
    assign bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire
